// File: rtl/generals_pkg.sv
// Shared types for the PS/2 keyboard command path: game command codes,
// receiver FSM states, scan-code set 2 constants and the key map.
package generals_pkg;

    typedef enum logic [2:0] {
        KEY_NONE   = 3'd0,
        KEY_UP     = 3'd1,
        KEY_DOWN   = 3'd2,
        KEY_LEFT   = 3'd3,
        KEY_RIGHT  = 3'd4,
        KEY_SELECT = 3'd5,
        KEY_HALF   = 3'd6,
        KEY_ESC    = 3'd7
    } key_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_RECV,
        RX_CHECK
    } rx_state_t;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_UP_X  = 8'h75;
    localparam logic [7:0] SC_DN_X  = 8'h72;
    localparam logic [7:0] SC_LT_X  = 8'h6B;
    localparam logic [7:0] SC_RT_X  = 8'h74;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_J     = 8'h3B;
    localparam logic [7:0] SC_Z     = 8'h1A;
    localparam logic [7:0] SC_ESC   = 8'h76;

    // Letter arrow aliases are accepted with or without an E0 prefix;
    // cursor-pad arrows need E0; all other keys need it absent.
    function automatic key_t map_scan(input logic ext, input logic [7:0] code);
        key_t k;
        k = KEY_NONE;
        case (code)
            SC_W:           k = KEY_UP;
            SC_S:           k = KEY_DOWN;
            SC_A:           k = KEY_LEFT;
            SC_D:           k = KEY_RIGHT;
            SC_UP_X:        if (ext)  k = KEY_UP;
            SC_DN_X:        if (ext)  k = KEY_DOWN;
            SC_LT_X:        if (ext)  k = KEY_LEFT;
            SC_RT_X:        if (ext)  k = KEY_RIGHT;
            SC_SPACE, SC_J: if (!ext) k = KEY_SELECT;
            SC_Z:           if (!ext) k = KEY_HALF;
            SC_ESC:         if (!ext) k = KEY_ESC;
            default:        k = KEY_NONE;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, 11-bit
// shift-in, start/parity/stop check and inter-edge timeout.
module ps2_rx_frame
    import generals_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 200_000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       err
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   fall;
    logic                   bit_in;
    rx_state_t              state;
    logic [3:0]             bit_cnt;
    logic [9:0]             frame;
    logic [TIMER_W-1:0]     timer;

    // Synchronise both pins (idle high) and keep the previous clock level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fall   = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign bit_in = data_sync[SYNC_STAGES-1];

    // Frame FSM. The check result is registered on entry to RX_CHECK so that
    // byte_valid/err are high exactly for the single RX_CHECK cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RX_IDLE;
            bit_cnt    <= '0;
            frame      <= '0;
            timer      <= '0;
            byte_valid <= 1'b0;
            rx_byte    <= '0;
            err        <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            err        <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (fall) begin
                        frame[0] <= bit_in;
                        bit_cnt  <= 4'd1;
                        timer    <= '0;
                        state    <= RX_RECV;
                    end
                end
                RX_RECV: begin
                    if (fall) begin
                        timer <= '0;
                        if (bit_cnt == 4'd10) begin
                            rx_byte <= frame[8:1];
                            if (!frame[0] && (^frame[9:1]) && bit_in)
                                byte_valid <= 1'b1;
                            else
                                err <= 1'b1;
                            state <= RX_CHECK;
                        end else begin
                            frame[bit_cnt] <= bit_in;
                            bit_cnt        <= bit_cnt + 4'd1;
                        end
                    end else if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                        err   <= 1'b1;
                        state <= RX_IDLE;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                RX_CHECK: state <= RX_IDLE;
                default:  state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ps2_keyboard_decoder.sv
// PS/2 keyboard to game-command decoder: E0/F0 prefix tracking, scan-code
// mapping and registered keyboard_locker/keyboard_data/frame_err outputs.
// Optional macro PS2_TYPEMATIC_FILTER_EN: suppress repeated makes of a key
// that is already held down.
module ps2_keyboard_decoder
    import generals_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 200_000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       keyboard_locker,
    output logic [2:0] keyboard_data,
    output logic       frame_err
);

    logic       byte_valid;
    logic       rx_err;
    logic [7:0] rx_byte;
    logic       ext;
    logic       brk;
    key_t       key;
`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [7:0] held;
`endif

    ps2_rx_frame #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .SYNC_STAGES   (SYNC_STAGES)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .byte_valid(byte_valid),
        .rx_byte   (rx_byte),
        .err       (rx_err)
    );

    assign key = map_scan(ext, rx_byte);

    // Prefix flags, command strobe and held-key tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keyboard_locker <= 1'b0;
            keyboard_data   <= KEY_NONE;
            frame_err       <= 1'b0;
            ext             <= 1'b0;
            brk             <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
            held            <= '0;
`endif
        end else begin
            keyboard_locker <= 1'b0;
            frame_err       <= 1'b0;
            if (rx_err) begin
                frame_err <= 1'b1;
                ext       <= 1'b0;
                brk       <= 1'b0;
            end else if (byte_valid) begin
                if (rx_byte == SC_EXT) begin
                    ext <= 1'b1;
                end else if (rx_byte == SC_BRK) begin
                    brk <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (brk) begin
`ifdef PS2_TYPEMATIC_FILTER_EN
                        held[key] <= 1'b0;
`endif
                    end else if (key != KEY_NONE) begin
`ifdef PS2_TYPEMATIC_FILTER_EN
                        if (!held[key]) begin
                            keyboard_locker <= 1'b1;
                            keyboard_data   <= key;
                        end
                        held[key] <= 1'b1;
`else
                        keyboard_locker <= 1'b1;
                        keyboard_data   <= key;
`endif
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
// Bench for ps2_keyboard_decoder: directed scenarios plus random scan-code
// traffic, checked every cycle against a behavioural keyboard model.
module tb_ps2_keyboard_decoder;

    localparam int unsigned T = 300;
    localparam int unsigned S = 2;
    localparam int unsigned H = 8;
`ifdef PS2_TYPEMATIC_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    localparam logic [7:0] ARROW_PLAIN [4] = '{8'h1D, 8'h1B, 8'h1C, 8'h23};
    localparam logic [7:0] ARROW_EXT   [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};
    localparam logic [7:0] POOL [14] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72, 8'h6B,
                                         8'h74, 8'h29, 8'h3B, 8'h1A, 8'h76, 8'hE0, 8'hF0};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       keyboard_locker;
    logic [2:0] keyboard_data;
    logic       frame_err;

    ps2_keyboard_decoder #(
        .TIMEOUT_CYCLES(T),
        .SYNC_STAGES   (S)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ps2_clk        (ps2_clk),
        .ps2_data       (ps2_data),
        .keyboard_locker(keyboard_locker),
        .keyboard_data  (keyboard_data),
        .frame_err      (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state
    bit         m_ext, m_brk;
    bit   [7:0] m_held;
    logic [2:0] m_data = 3'd0;
    bit         exp_strobe [int];
    logic [2:0] exp_val    [int];
    int         err_lo, err_hi;
    bit         err_pending = 1'b0, err_seen = 1'b0;

    int         checks = 0, errors = 0;
    int         strobes = 0, errs = 0, last_strobe_cyc = 0;
    logic [2:0] last_strobe_data = 3'd0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic logic [2:0] model_key(input bit ext, input logic [7:0] b);
        for (int i = 0; i < 4; i++) begin
            if (b == ARROW_PLAIN[i]) return 3'(i + 1);
            if (ext && b == ARROW_EXT[i]) return 3'(i + 1);
        end
        if (!ext) begin
            if (b == 8'h29 || b == 8'h3B) return 3'd5;
            if (b == 8'h1A) return 3'd6;
            if (b == 8'h76) return 3'd7;
        end
        return 3'd0;
    endfunction

    // Called just before the stop-bit falling edge is driven at cycle n.
    task automatic model_frame(input logic [7:0] b, input bit good, input int n);
        logic [2:0] k;
        if (!good) begin
            err_lo = n + S + 2; err_hi = n + S + 2; err_pending = 1'b1; err_seen = 1'b0;
            m_ext = 1'b0; m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            k = model_key(m_ext, b);
            if (m_brk) begin
                if (FILTER) m_held[k] = 1'b0;
            end else if (k != 3'd0) begin
                if (!(FILTER && m_held[k])) begin
                    exp_strobe[n + S + 2] = 1'b1;
                    exp_val[n + S + 2]    = k;
                end
                m_held[k] = 1'b1;
            end
            m_ext = 1'b0; m_brk = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_ext = 1'b0; m_brk = 1'b0; m_held = '0; m_data = 3'd0;
        exp_strobe.delete(); exp_val.delete(); err_pending = 1'b0;
    endtask

    // Sends the first nbits bits of a frame; full frames update the model.
    task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input int nbits, output int n_last);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        n_last = 0;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            tick(H);
            n_last = cyc;
            if (i == 10) model_frame(b, !bad_par && !bad_stop, n_last);
            ps2_clk = 1'b0;
            tick(H);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              output int n_last);
        send_bits(b, bad_par, bad_stop, 11, n_last);
        tick(2);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        bit ok_err;
        if (exp_strobe.exists(cyc)) begin
            check("keyboard_locker", {15'd0, keyboard_locker}, 16'd1);
            m_data = exp_val[cyc];
            exp_strobe.delete(cyc);
            exp_val.delete(cyc);
        end else begin
            check("keyboard_locker", {15'd0, keyboard_locker}, 16'd0);
        end
        check("keyboard_data", {13'd0, keyboard_data}, {13'd0, m_data});
        if (keyboard_locker === 1'b1) begin
            strobes++;
            last_strobe_cyc  = cyc;
            last_strobe_data = keyboard_data;
        end
        ok_err = 1'b1;
        if (frame_err !== 1'b0) begin
            errs++;
            if (err_pending && !err_seen && cyc >= err_lo && cyc <= err_hi) err_seen = 1'b1;
            else ok_err = 1'b0;
        end
        if (err_pending && cyc >= err_hi) begin
            if (!err_seen) ok_err = 1'b0;
            err_pending = 1'b0;
        end
        check("frame_err_timing", {15'd0, ok_err}, 16'd1);
    end

    initial begin
        int n, s0, e0, r, gap;
        logic [7:0] b;
        bit bp, bs;

        // Reset state
        tick(3);
        check("reset_locker", {15'd0, keyboard_locker}, 16'd0);
        check("reset_data", {13'd0, keyboard_data}, 16'd0);
        check("reset_err", {15'd0, frame_err}, 16'd0);
        rst_n = 1'b1;
        tick(5);

        // 1: single make of 0x1D, exact latency
        s0 = strobes;
        send_frame(8'h1D, 1'b0, 1'b0, n);
        tick(6);
        check("t1_strobes", 16'(strobes - s0), 16'd1);
        check("t1_latency", 16'(last_strobe_cyc - n), 16'(S + 2));
        check("t1_data", {13'd0, last_strobe_data}, 16'd1);

        // 2: extended make then extended break of right arrow
        s0 = strobes;
        send_frame(8'hE0, 1'b0, 1'b0, n);
        send_frame(8'h74, 1'b0, 1'b0, n);
        send_frame(8'hE0, 1'b0, 1'b0, n);
        send_frame(8'hF0, 1'b0, 1'b0, n);
        send_frame(8'h74, 1'b0, 1'b0, n);
        tick(6);
        check("t2_strobes", 16'(strobes - s0), 16'd1);
        check("t2_data", {13'd0, keyboard_data}, 16'd4);

        // 3: parity error on 0x29
        s0 = strobes; e0 = errs;
        send_frame(8'h29, 1'b1, 1'b0, n);
        tick(6);
        check("t3_errs", 16'(errs - e0), 16'd1);
        check("t3_strobes", 16'(strobes - s0), 16'd0);
        check("t3_data_held", {13'd0, keyboard_data}, 16'd4);

        // 4: truncated frame times out, then 0x76
        s0 = strobes; e0 = errs;
        send_bits(8'h76, 1'b0, 1'b0, 5, n);
        err_lo = n + S + T; err_hi = n + S + T + 4; err_seen = 1'b0; err_pending = 1'b1;
        m_ext = 1'b0; m_brk = 1'b0;
        tick(T + 30);
        check("t4_timeout_errs", 16'(errs - e0), 16'd1);
        check("t4_no_strobe", 16'(strobes - s0), 16'd0);
        send_frame(8'h76, 1'b0, 1'b0, n);
        tick(6);
        check("t4_strobes", 16'(strobes - s0), 16'd1);
        check("t4_data", {13'd0, keyboard_data}, 16'd7);

        // 5: typematic repeats of 0x1C
        s0 = strobes;
        for (int i = 0; i < 3; i++) send_frame(8'h1C, 1'b0, 1'b0, n);
        send_frame(8'hF0, 1'b0, 1'b0, n);
        send_frame(8'h1C, 1'b0, 1'b0, n);
        send_frame(8'h1C, 1'b0, 1'b0, n);
        tick(6);
        check("t5_strobes", 16'(strobes - s0), FILTER ? 16'd2 : 16'd4);
        check("t5_data", {13'd0, keyboard_data}, 16'd3);

        // 6: reset mid-frame, then a clean 0x1A
        send_bits(8'h1A, 1'b0, 1'b0, 5, n);
        tick(2);
        rst_n = 1'b0;
        model_reset();
        tick(3);
        check("t6_reset_data", {13'd0, keyboard_data}, 16'd0);
        rst_n = 1'b1;
        tick(5);
        s0 = strobes; e0 = errs;
        send_frame(8'h1A, 1'b0, 1'b0, n);
        tick(6);
        check("t6_errs", 16'(errs - e0), 16'd0);
        check("t6_strobes", 16'(strobes - s0), 16'd1);
        check("t6_data", {13'd0, keyboard_data}, 16'd6);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            r  = int'($urandom_range(0, 15));
            b  = (r < 14) ? POOL[r] : 8'($urandom);
            bp = ($urandom_range(0, 7) == 0);
            bs = !bp && ($urandom_range(0, 15) == 0);
            send_frame(b, bp, bs, n);
            gap = int'($urandom_range(0, 20));
            if (gap > 0) tick(gap);
        end
        tick(20);
        check("final_err_pending", {15'd0, err_pending}, 16'd0);
        check("final_strobes_pending", 16'(exp_strobe.num()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
